// File: rtl/ti_pipe_bank_pkg.sv
// ti_pipe_bank_pkg: shared definitions for the host pipe buffer bank.
// Holds the data width, endpoint base addresses and the parameter
// legality check used by the bank top level.
package ti_pipe_bank_pkg;

    localparam int TI_DATA_W = 16;

    // Endpoint base addresses on the host interface
    localparam logic [7:0] TI_EP_WIREOUT = 8'h20;
    localparam logic [7:0] TI_EP_PIPEIN  = 8'h80;
    localparam logic [7:0] TI_EP_PIPEOUT = 8'hA0;

    typedef logic [TI_DATA_W-1:0] ti_word_t;

    // Channel count 1..8, FIFO address width 4..15
    function automatic bit ti_params_ok(input int num_ch, input int maw);
        return (num_ch >= 1) && (num_ch <= 8) && (maw >= 4) && (maw <= 15);
    endfunction

endpackage

// File: rtl/ti_pipe_fifo.sv
// ti_pipe_fifo: first-word-fall-through FIFO with exact count and flush.
// The head word lives in a register that is reloaded every edge with the
// word that will be at the head afterwards, so a push into an empty FIFO
// is visible one cycle later and push/pop sustain one word per cycle.
// The head register is 0 whenever the FIFO is empty.
module ti_pipe_fifo
    import ti_pipe_bank_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_push,
    input  ti_word_t                i_push_data,
    input  logic                    i_pop,
    output ti_word_t                o_head,
    output logic [MEM_ADDR_WIDTH:0] o_count
);

    localparam int AW    = MEM_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    ti_word_t        r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    ti_word_t        r_head;

    logic            w_empty;
    logic            w_full;
    logic            w_pop_ok;
    logic            w_push_ok;
    logic [AW:0]     w_cnt_after_pop;
    logic [AW:0]     w_count_nxt;
    logic [AW-1:0]   w_rd_ptr_nxt;
    ti_word_t        w_head_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    // A pop frees a slot in the same cycle, so a push at full is still taken
    assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
    assign w_push_ok = i_push & ~i_flush & (~w_full | w_pop_ok);

    assign w_cnt_after_pop = w_pop_ok  ? (r_count - CNT_ONE) : r_count;
    assign w_count_nxt     = w_push_ok ? (w_cnt_after_pop + CNT_ONE) : w_cnt_after_pop;
    assign w_rd_ptr_nxt    = w_pop_ok  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    // Select the word that will sit at the head after this edge
    always_comb begin
        w_head_nxt = '0;
        if (i_flush || (w_count_nxt == '0)) begin
            w_head_nxt = '0;
        end else if (w_cnt_after_pop == '0) begin
            // FIFO drains (or was empty): the incoming word bypasses storage
            w_head_nxt = i_push_data;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, count and head register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/ti_pipe_bank.sv
// ti_pipe_bank: NUM_CH independent channels, each with a host-to-user and a
// user-to-host FWFT FIFO. Adds occupancy reporting, sticky overflow and
// underflow flags and a per-channel soft flush.
module ti_pipe_bank
    import ti_pipe_bank_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                           ti_clk,
    input  logic                           ti_rst,
    input  logic [NUM_CH-1:0]              ti_rst_soft,
    input  logic [NUM_CH-1:0]              ti_in_data_en,
    input  logic [TI_DATA_W*NUM_CH-1:0]    ti_in_data,
    output logic [TI_DATA_W*NUM_CH-1:0]    ti_in_available,
    input  logic [NUM_CH-1:0]              ti_out_data_en,
    output logic [TI_DATA_W*NUM_CH-1:0]    ti_out_data,
    output logic [TI_DATA_W*NUM_CH-1:0]    ti_out_available,
    output logic [NUM_CH-1:0]              ti_overflow,
    output logic [NUM_CH-1:0]              ti_underflow,
    output logic [NUM_CH-1:0]              s_in_valid,
    input  logic [NUM_CH-1:0]              s_in_ready,
    output logic [TI_DATA_W*NUM_CH-1:0]    s_in_data,
    input  logic [NUM_CH-1:0]              s_out_valid,
    output logic [NUM_CH-1:0]              s_out_ready,
    input  logic [TI_DATA_W*NUM_CH-1:0]    s_out_data
);

    localparam int          AW       = MEM_ADDR_WIDTH;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [15:0] DEPTH16  = 16'(1 << AW);

    if (!ti_params_ok(NUM_CH, MEM_ADDR_WIDTH)) begin : g_bad_params
        $error("ti_pipe_bank: NUM_CH must be 1..8 and MEM_ADDR_WIDTH 4..15");
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [AW:0] w_h2u_cnt;
        logic [AW:0] w_u2h_cnt;
        logic        w_h2u_pop;
        logic        w_u2h_push;
        logic        r_ovf;
        logic        r_und;
        logic        r_flush_d;

        assign w_h2u_pop  = s_in_valid[c] & s_in_ready[c];
        assign w_u2h_push = s_out_valid[c] & s_out_ready[c];

        ti_pipe_fifo #(.MEM_ADDR_WIDTH(AW)) u_h2u (
            .i_clk       (ti_clk),
            .i_rst       (ti_rst),
            .i_flush     (ti_rst_soft[c]),
            .i_push      (ti_in_data_en[c]),
            .i_push_data (ti_in_data[TI_DATA_W*c +: TI_DATA_W]),
            .i_pop       (w_h2u_pop),
            .o_head      (s_in_data[TI_DATA_W*c +: TI_DATA_W]),
            .o_count     (w_h2u_cnt)
        );

        ti_pipe_fifo #(.MEM_ADDR_WIDTH(AW)) u_u2h (
            .i_clk       (ti_clk),
            .i_rst       (ti_rst),
            .i_flush     (ti_rst_soft[c]),
            .i_push      (w_u2h_push),
            .i_push_data (s_out_data[TI_DATA_W*c +: TI_DATA_W]),
            .i_pop       (ti_out_data_en[c]),
            .o_head      (ti_out_data[TI_DATA_W*c +: TI_DATA_W]),
            .o_count     (w_u2h_cnt)
        );

        // All status outputs derive from registered state only
        assign s_in_valid[c]  = (w_h2u_cnt != '0);
        assign s_out_ready[c] = (w_u2h_cnt != FULL_CNT) & ~r_flush_d;
        assign ti_in_available[TI_DATA_W*c +: TI_DATA_W]  = DEPTH16 - 16'(w_h2u_cnt);
        assign ti_out_available[TI_DATA_W*c +: TI_DATA_W] = 16'(w_u2h_cnt);
        assign ti_overflow[c]  = r_ovf;
        assign ti_underflow[c] = r_und;

        // Sticky flags, cleared by flush; flush is delayed to hold off the user
        always_ff @(posedge ti_clk or posedge ti_rst) begin
            if (ti_rst) begin
                r_ovf     <= 1'b0;
                r_und     <= 1'b0;
                r_flush_d <= 1'b0;
            end else begin
                r_flush_d <= ti_rst_soft[c];
                if (ti_rst_soft[c]) begin
                    r_ovf <= 1'b0;
                    r_und <= 1'b0;
                end else begin
                    if (ti_in_data_en[c] && (w_h2u_cnt == FULL_CNT) && !w_h2u_pop) begin
                        r_ovf <= 1'b1;
                    end
                    if (ti_out_data_en[c] && (w_u2h_cnt == '0)) begin
                        r_und <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ti_pipe_bank.sv
// tb_ti_pipe_bank: scoreboard bench for ti_pipe_bank with 2 channels of
// 16-word FIFOs. Expected words are queued when driven and compared when
// the DUT presents them.
module tb_ti_pipe_bank;

    localparam int NCH   = 2;
    localparam int MAW   = 4;
    localparam int DEPTH = 16;

    logic                 ti_clk = 1'b0;
    logic                 ti_rst;
    logic [NCH-1:0]       ti_rst_soft;
    logic [NCH-1:0]       ti_in_data_en;
    logic [16*NCH-1:0]    ti_in_data;
    logic [16*NCH-1:0]    ti_in_available;
    logic [NCH-1:0]       ti_out_data_en;
    logic [16*NCH-1:0]    ti_out_data;
    logic [16*NCH-1:0]    ti_out_available;
    logic [NCH-1:0]       ti_overflow;
    logic [NCH-1:0]       ti_underflow;
    logic [NCH-1:0]       s_in_valid;
    logic [NCH-1:0]       s_in_ready;
    logic [16*NCH-1:0]    s_in_data;
    logic [NCH-1:0]       s_out_valid;
    logic [NCH-1:0]       s_out_ready;
    logic [16*NCH-1:0]    s_out_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] qh0[$];
    logic [15:0] qu1[$];

    ti_pipe_bank #(.NUM_CH(NCH), .MEM_ADDR_WIDTH(MAW)) dut (
        .ti_clk           (ti_clk),
        .ti_rst           (ti_rst),
        .ti_rst_soft      (ti_rst_soft),
        .ti_in_data_en    (ti_in_data_en),
        .ti_in_data       (ti_in_data),
        .ti_in_available  (ti_in_available),
        .ti_out_data_en   (ti_out_data_en),
        .ti_out_data      (ti_out_data),
        .ti_out_available (ti_out_available),
        .ti_overflow      (ti_overflow),
        .ti_underflow     (ti_underflow),
        .s_in_valid       (s_in_valid),
        .s_in_ready       (s_in_ready),
        .s_in_data        (s_in_data),
        .s_out_valid      (s_out_valid),
        .s_out_ready      (s_out_ready),
        .s_out_data       (s_out_data)
    );

    always #5 ti_clk = ~ti_clk;

    task automatic tick;
        @(posedge ti_clk);
        #1;
    endtask

    task automatic idle_inputs;
        ti_rst_soft    = '0;
        ti_in_data_en  = '0;
        ti_in_data     = '0;
        ti_out_data_en = '0;
        s_in_ready     = '0;
        s_out_valid    = '0;
        s_out_data     = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        ti_rst = 1'b1;
        tick(); tick();
        ti_rst = 1'b0;
        tick();
        for (int c = 0; c < NCH; c++) begin
            n_total++;
            if (ti_in_available[16*c +: 16] !== 16'd16)
                $display("FAIL reset_in_avail ch%0d got %0d exp 16", c, ti_in_available[16*c +: 16]);
            else n_pass++;
            n_total++;
            if (ti_out_available[16*c +: 16] !== 16'd0)
                $display("FAIL reset_out_avail ch%0d got %0d exp 0", c, ti_out_available[16*c +: 16]);
            else n_pass++;
            n_total++;
            if ({ti_out_data[16*c +: 16], s_in_data[16*c +: 16]} !== 32'h0)
                $display("FAIL reset_data ch%0d got %h exp 0", c, {ti_out_data[16*c +: 16], s_in_data[16*c +: 16]});
            else n_pass++;
        end
        n_total++;
        if ({s_in_valid, s_out_ready, ti_overflow, ti_underflow} !== 8'b00_11_00_00)
            $display("FAIL reset_status got %b exp 00110000", {s_in_valid, s_out_ready, ti_overflow, ti_underflow});
        else n_pass++;
    endtask

    task automatic test_h2u_hold;
        logic [15:0] exp;
        ti_in_data_en[0]  = 1'b1;
        ti_in_data[15:0]  = 16'h1234;
        qh0.push_back(16'h1234);
        tick();
        ti_in_data_en = '0;
        n_total++;
        if ({s_in_valid[0], s_in_data[15:0]} !== {1'b1, qh0[0]})
            $display("FAIL h2u_first got %b/%h exp 1/%h", s_in_valid[0], s_in_data[15:0], qh0[0]);
        else n_pass++;
        n_total++;
        if (ti_in_available[15:0] !== 16'd15)
            $display("FAIL h2u_avail got %0d exp 15", ti_in_available[15:0]);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if ({s_in_valid[0], s_in_data[15:0]} !== {1'b1, qh0[0]})
                $display("FAIL h2u_hold cyc%0d got %b/%h exp 1/%h", i, s_in_valid[0], s_in_data[15:0], qh0[0]);
            else n_pass++;
        end
        n_total++;
        if ({s_in_valid[1], s_in_data[31:16], ti_in_available[31:16]} !== {1'b0, 16'h0, 16'd16})
            $display("FAIL ch1_untouched got %b/%h/%0d exp 0/0000/16", s_in_valid[1], s_in_data[31:16], ti_in_available[31:16]);
        else n_pass++;
        s_in_ready[0] = 1'b1;
        exp = qh0.pop_front();
        n_total++;
        if (s_in_data[15:0] !== exp)
            $display("FAIL h2u_pop got %h exp %h", s_in_data[15:0], exp);
        else n_pass++;
        tick();
        s_in_ready = '0;
        n_total++;
        if ({s_in_valid[0], ti_in_available[15:0]} !== {1'b0, 16'd16})
            $display("FAIL h2u_drained got %b/%0d exp 0/16", s_in_valid[0], ti_in_available[15:0]);
        else n_pass++;
    endtask

    task automatic test_u2h_full;
        logic [15:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            s_out_valid[1]    = 1'b1;
            s_out_data[31:16] = 16'(i);
            qu1.push_back(16'(i));
            tick();
        end
        n_total++;
        if ({s_out_ready[1], ti_out_available[31:16]} !== {1'b0, 16'd16})
            $display("FAIL u2h_full got %b/%0d exp 0/16", s_out_ready[1], ti_out_available[31:16]);
        else n_pass++;
        s_out_data[31:16] = 16'h0011;
        tick();
        s_out_valid = '0;
        n_total++;
        if (ti_out_available[31:16] !== 16'd16)
            $display("FAIL u2h_17th got %0d exp 16", ti_out_available[31:16]);
        else n_pass++;
        ti_out_data_en[1] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = qu1.pop_front();
            n_total++;
            if ({ti_out_data[31:16], ti_out_available[31:16]} !== {exp, 16'(DEPTH - i)})
                $display("FAIL u2h_read i%0d got %h/%0d exp %h/%0d", i, ti_out_data[31:16], ti_out_available[31:16], exp, DEPTH - i);
            else n_pass++;
            tick();
        end
        ti_out_data_en = '0;
        n_total++;
        if ({ti_out_data[31:16], ti_out_available[31:16], ti_underflow[1], s_out_ready[1]} !== {16'h0, 16'd0, 1'b0, 1'b1})
            $display("FAIL u2h_empty got %h/%0d/%b/%b exp 0000/0/0/1", ti_out_data[31:16], ti_out_available[31:16], ti_underflow[1], s_out_ready[1]);
        else n_pass++;
    endtask

    task automatic test_full_simul;
        logic [15:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            ti_in_data_en[0] = 1'b1;
            ti_in_data[15:0] = 16'h0100 + 16'(i);
            qh0.push_back(16'h0100 + 16'(i));
            tick();
        end
        ti_in_data_en = '0;
        n_total++;
        if (ti_in_available[15:0] !== 16'd0)
            $display("FAIL full_avail got %0d exp 0", ti_in_available[15:0]);
        else n_pass++;
        ti_in_data_en[0] = 1'b1;
        ti_in_data[15:0] = 16'hBEEF;
        s_in_ready[0]    = 1'b1;
        exp = qh0.pop_front();
        qh0.push_back(16'hBEEF);
        n_total++;
        if (s_in_data[15:0] !== exp)
            $display("FAIL full_simul_head got %h exp %h", s_in_data[15:0], exp);
        else n_pass++;
        tick();
        ti_in_data_en = '0;
        s_in_ready    = '0;
        n_total++;
        if ({ti_in_available[15:0], ti_overflow[0]} !== {16'd0, 1'b0})
            $display("FAIL full_simul got %0d/%b exp 0/0", ti_in_available[15:0], ti_overflow[0]);
        else n_pass++;
        ti_in_data_en[0] = 1'b1;
        ti_in_data[15:0] = 16'hDEAD;
        tick();
        ti_in_data_en = '0;
        n_total++;
        if ({ti_in_available[15:0], ti_overflow[0]} !== {16'd0, 1'b1})
            $display("FAIL overflow_set got %0d/%b exp 0/1", ti_in_available[15:0], ti_overflow[0]);
        else n_pass++;
        s_in_ready[0] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp = qh0.pop_front();
            n_total++;
            if ({s_in_valid[0], s_in_data[15:0]} !== {1'b1, exp})
                $display("FAIL full_drain i%0d got %b/%h exp 1/%h", i, s_in_valid[0], s_in_data[15:0], exp);
            else n_pass++;
            tick();
        end
        s_in_ready = '0;
        n_total++;
        if ({s_in_valid[0], ti_overflow[0]} !== 2'b01)
            $display("FAIL overflow_sticky got %b/%b exp 0/1", s_in_valid[0], ti_overflow[0]);
        else n_pass++;
        ti_rst_soft[0] = 1'b1;
        tick();
        ti_rst_soft = '0;
        tick();
        n_total++;
        if (ti_overflow[0] !== 1'b0)
            $display("FAIL overflow_clear got %b exp 0", ti_overflow[0]);
        else n_pass++;
    endtask

    task automatic test_underflow;
        ti_out_data_en[0] = 1'b1;
        tick();
        ti_out_data_en = '0;
        n_total++;
        if ({ti_out_data[15:0], ti_out_available[15:0], ti_underflow} !== {16'h0, 16'd0, 2'b01})
            $display("FAIL underflow got %h/%0d/%b exp 0000/0/01", ti_out_data[15:0], ti_out_available[15:0], ti_underflow);
        else n_pass++;
    endtask

    task automatic test_flush;
        for (int i = 0; i < 8; i++) begin
            ti_in_data_en[0] = 1'b1;
            ti_in_data[15:0] = 16'h0A00 + 16'(i);
            s_out_valid[0]   = 1'b1;
            s_out_data[15:0] = 16'h0B00 + 16'(i);
            tick();
        end
        n_total++;
        if ({ti_in_available[15:0], ti_out_available[15:0], ti_underflow[0]} !== {16'd8, 16'd8, 1'b1})
            $display("FAIL flush_pre got %0d/%0d/%b exp 8/8/1", ti_in_available[15:0], ti_out_available[15:0], ti_underflow[0]);
        else n_pass++;
        ti_rst_soft[0] = 1'b1;
        ti_in_data[15:0] = 16'h7777;
        ti_out_data_en[0] = 1'b1;
        tick();
        n_total++;
        if ({ti_in_available[15:0], ti_out_available[15:0], s_in_valid[0], s_out_ready[0], ti_overflow[0], ti_underflow[0]} !== {16'd16, 16'd0, 4'b0000})
            $display("FAIL flush_pulse got %0d/%0d/%b%b%b%b exp 16/0/0000", ti_in_available[15:0], ti_out_available[15:0], s_in_valid[0], s_out_ready[0], ti_overflow[0], ti_underflow[0]);
        else n_pass++;
        tick();
        n_total++;
        if ({ti_in_available[15:0], ti_out_available[15:0], s_out_ready[0], ti_underflow[0]} !== {16'd16, 16'd0, 2'b00})
            $display("FAIL flush_hold got %0d/%0d/%b/%b exp 16/0/0/0", ti_in_available[15:0], ti_out_available[15:0], s_out_ready[0], ti_underflow[0]);
        else n_pass++;
        idle_inputs();
        tick();
        n_total++;
        if ({s_out_ready[0], ti_in_available[15:0], s_in_data[15:0]} !== {1'b1, 16'd16, 16'h0})
            $display("FAIL flush_release got %b/%0d/%h exp 1/16/0000", s_out_ready[0], ti_in_available[15:0], s_in_data[15:0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp;
        logic        exp_ovf;
        logic        en;
        logic        rdy;
        logic [15:0] d;
        exp_ovf = 1'b0;
        for (int i = 0; i < 60; i++) begin
            en  = (i < 30) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rdy = (i < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            d   = 16'($urandom);
            ti_in_data_en[0] = en;
            ti_in_data[15:0] = d;
            s_in_ready[0]    = rdy;
            if (rdy && qh0.size() > 0) begin
                exp = qh0.pop_front();
                n_total++;
                if (s_in_data[15:0] !== exp)
                    $display("FAIL b2b_data cyc%0d got %h exp %h", i, s_in_data[15:0], exp);
                else n_pass++;
            end
            if (en) begin
                if (qh0.size() < DEPTH) qh0.push_back(d);
                else exp_ovf = 1'b1;
            end
            tick();
            n_total++;
            if ({ti_in_available[15:0], ti_overflow[0]} !== {16'(DEPTH - qh0.size()), exp_ovf})
                $display("FAIL b2b_state cyc%0d got %0d/%b exp %0d/%b", i, ti_in_available[15:0], ti_overflow[0], DEPTH - qh0.size(), exp_ovf);
            else n_pass++;
        end
        idle_inputs();
        ti_rst_soft[0] = 1'b1;
        tick();
        ti_rst_soft = '0;
        qh0.delete();
        tick();
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) begin
            ti_in_data_en[1]  = 1'b1;
            ti_in_data[31:16] = 16'h0C00 + 16'(i);
            s_out_valid[1]    = 1'b1;
            s_out_data[31:16] = 16'h0D00 + 16'(i);
            tick();
        end
        #2;
        ti_rst = 1'b1;
        #1;
        n_total++;
        if ({ti_in_available[31:16], ti_out_available[31:16], ti_out_data[31:16], s_in_data[31:16]} !== {16'd16, 16'd0, 16'h0, 16'h0})
            $display("FAIL rst_mid_ch1 got %0d/%0d/%h/%h exp 16/0/0000/0000", ti_in_available[31:16], ti_out_available[31:16], ti_out_data[31:16], s_in_data[31:16]);
        else n_pass++;
        n_total++;
        if ({s_in_valid, s_out_ready, ti_overflow, ti_underflow} !== 8'b00_11_00_00)
            $display("FAIL rst_mid_status got %b exp 00110000", {s_in_valid, s_out_ready, ti_overflow, ti_underflow});
        else n_pass++;
        idle_inputs();
        tick();
        ti_rst = 1'b0;
        tick();
        n_total++;
        if ({ti_in_available[31:16], ti_out_available[31:16]} !== {16'd16, 16'd0})
            $display("FAIL rst_mid_after got %0d/%0d exp 16/0", ti_in_available[31:16], ti_out_available[31:16]);
        else n_pass++;
    endtask

    initial begin
        ti_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_h2u_hold();
        test_u2h_full();
        test_full_simul();
        test_underflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
